// File: rtl/pattern_scan_ctrl.sv
// Serial pattern-scan controller.
// Accepts a start request with a pattern/length/overlap configuration, then
// consumes cfg_len serial bits under a valid/ready handshake, pulsing and
// counting every occurrence of the pattern in the stream. A one-cycle DONE
// state marks the end of each scan before returning to IDLE.
module pattern_scan_ctrl #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [7:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic             bit_valid,
  input  logic             x,
  output logic             bit_ready,
  output logic             busy,
  output logic             done,
  output logic             match_pulse,
  output logic [7:0]       match_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Fill counter saturates at the pattern length; 4 bits covers PAT_W up to 8.
  localparam logic [3:0] FULL = 4'(PAT_W);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [7:0]       len_q;
  logic             overlap_q;
  logic [PAT_W-1:0] shreg;
  logic [3:0]       fill;
  logic [7:0]       seen;

  logic [PAT_W-1:0] shreg_nxt;
  logic [3:0]       fill_inc;
  logic             hit;
  logic             last_bit;

  // Ready depends on the state alone so upstream never sees a combinational loop.
  assign bit_ready = (state == SCAN);

  // Window, fill and end-of-scan evaluation for the bit currently presented.
  always_comb begin
    shreg_nxt = {shreg[PAT_W-2:0], x};
    fill_inc  = (fill == FULL) ? FULL : fill + 4'd1;
    hit       = (fill_inc == FULL) && (shreg_nxt == pat_q);
    last_bit  = ((seen + 8'd1) == len_q);
  end

  // Control FSM with registered status outputs and scan datapath state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      overlap_q   <= 1'b0;
      shreg       <= '0;
      fill        <= '0;
      seen        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      match_pulse <= 1'b0;
      match_count <= '0;
    end else begin
      match_pulse <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pat_q       <= cfg_pattern;
            len_q       <= cfg_len;
            overlap_q   <= cfg_overlap;
            shreg       <= '0;
            fill        <= '0;
            seen        <= '0;
            match_count <= '0;
            busy        <= 1'b1;
            if (cfg_len != 8'd0) begin
              state <= SCAN;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (bit_valid) begin
            shreg <= shreg_nxt;
            seen  <= seen + 8'd1;
            if (hit) begin
              match_pulse <= 1'b1;
              match_count <= match_count + 8'd1;
              // Non-overlapping mode discards the matched window entirely.
              fill        <= overlap_q ? FULL : 4'd0;
            end else begin
              fill <= fill_inc;
            end
            if (last_bit) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 Parameter SHALL be: PAT_W, default 4, pattern length in bits (2..8).
REQ-002 Port clk SHALL be: input, 1, system clock; all state changes on rising edge.
REQ-003 Port rst SHALL be: input, 1, reset, asynchronous, active-low.
REQ-004 Port start SHALL be: input, 1, request to begin a scan; honoured only in IDLE.
REQ-005 Port cfg_pattern SHALL be: input, PAT_W, target pattern; bit [PAT_W-1] is the first bit received.
REQ-006 Port cfg_len SHALL be: input, 8, number of serial bits to scan.
REQ-007 Port cfg_overlap SHALL be: input, 1, 1 = overlapping detection, 0 = non-overlapping.
REQ-008 Port bit_valid SHALL be: input, 1, serial bit x is presented this cycle.
REQ-009 Port x SHALL be: input, 1, serial data bit.
REQ-010 Port bit_ready SHALL be: output, 1, controller accepts a bit this cycle.
REQ-011 Port busy SHALL be: output, 1, high in SCAN and DONE.
REQ-012 Port done SHALL be: output, 1, single-cycle end-of-scan pulse.
REQ-013 Port match_pulse SHALL be: output, 1, single-cycle pulse per detected match.
REQ-014 Port match_count SHALL be: output, 8, matches found in current or most recent scan.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SCAN, DONE.
REQ-016 In IDLE with start=1, the block SHALL latch cfg_pattern, cfg_len and cfg_overlap, clear match_count, shift register and fill counter, and go to SCAN if cfg_len!=0, else to DONE.
REQ-017 Config inputs SHALL be ignored outside the start-acceptance edge; start SHALL be ignored in SCAN and DONE.
REQ-018 bit_ready SHALL equal 1 exactly when state is SCAN (combinational from state only).
REQ-019 A bit SHALL be accepted on an edge where state=SCAN and bit_valid=1; edges with bit_valid=0 SHALL change nothing.
REQ-020 On acceptance: shift register <= {shreg[PAT_W-2:0], x}; fill counter increments, saturating at PAT_W; bits-seen counter increments.
REQ-021 A match SHALL occur on an acceptance edge when (fill after update)=PAT_W and the updated shift register equals the latched pattern.
REQ-022 On a match, match_pulse SHALL be registered high for exactly the following cycle, and match_count SHALL increment on the same edge.
REQ-023 On a match with overlap=0, the fill counter SHALL be cleared to 0 on that edge, so no bit of a matched window contributes to a later match; with overlap=1 it SHALL stay at PAT_W.
REQ-024 When the accepted bit is number cfg_len (bits-seen reaches latched cfg_len), the next state SHALL be DONE; a match on that last bit SHALL still be counted and pulsed.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start during DONE SHALL be ignored.
REQ-026 match_count SHALL hold its value in IDLE until the next accepted start; overflow cannot occur (max 255 bits).
REQ-027 Latency start->bit_ready SHALL be 1 cycle; last acceptance->done SHALL be 1 cycle.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, bit_ready=0, busy=0, done=0, match_pulse=0, match_count=0, and clear shift register and all counters, including mid-scan.
REQ-029 After rst deassertion the block SHALL require a new start; no scan resumes.

Verification
REQ-030 PAT_W=4, pattern 1011, overlap=0, len=7, stream 1,0,1,1,0,1,1 with bit_valid=1 -> one match_pulse (after 4th bit), match_count=1, done one cycle after 7th bit.
REQ-031 Same stream, overlap=1 -> match_pulses after 4th and 7th bits, match_count=2, match_pulse and done coincide in the cycle after the 7th bit.
REQ-032 len=0, start=1 -> bit_ready never asserted, done high in second cycle after start, match_count=0.
REQ-033 Pattern 1011, len=4, bit_valid toggled 1,0,0,1,1,0,1 with x=1,-,-,0,1,-,1 -> only valid bits taken, match_count=1, done after 4th accepted bit.
REQ-034 rst pulsed low mid-scan after 2 bits -> all outputs 0 asynchronously; a following start with len=4, stream 1011 -> match_count=1, no carry-over of earlier bits.
REQ-035 start held high across SCAN and DONE -> second scan begins only from IDLE, one cycle after done.
